// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants,
// common to the receive and transmit halves of the 8N1 link.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops load RESET_VAL so an idle-high line shows no edge after reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises Rx, samples each bit at mid-bit and
// presents complete frames in a holding register with ready/overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx,
    input  logic                 read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 busy,
    output rx_state_t            dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

    rx_state_t             state, state_next;
    logic                  rx_s, rx_d;
    logic                  fall, tick;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  arm, shift_en, good_stop, bad_stop, take;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (Rx),
        .q     (rx_s)
    );

    assign fall = rx_d & ~rx_s;
    assign tick = (cnt == '0);

    // Handshake: data_ready acts as valid for data_out; a one-cycle read
    // while data_ready=1 is the ready/accept and clears data_ready and overrun.
    assign take = read & data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall) state_next = START;
            START:   if (tick) state_next = rx_s ? IDLE : DATA;
            DATA:    if (tick && bit_idx == LAST_BIT) state_next = STOP;
            STOP:    if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        dbg_state = state;
        arm       = (state == IDLE) && fall;
        shift_en  = (state == DATA) && tick;
        good_stop = (state == STOP) && tick && rx_s;
        bad_stop  = (state == STOP) && tick && !rx_s;
    end

    // Counter reloads at every sample point, so it never free-runs through zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_d       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_d      <= rx_s;
            frame_err <= bad_stop;

            if (arm) begin
                cnt <= HALF_LOAD;
            end else if (state == IDLE) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= FULL_LOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end

            if (state == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (shift_en) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end

            // A new byte always wins; overrun only flags an unread byte lost.
            if (good_stop) begin
                data_out   <= shreg;
                data_ready <= 1'b1;
                if (take) begin
                    overrun <= 1'b0;
                end else if (data_ready) begin
                    overrun <= 1'b1;
                end
            end else if (take) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule
